// File: rtl/core_ibex_dut_mon_pkg.sv
// Shared types and constants for the Ibex DUT event monitor.
package core_ibex_dut_mon_pkg;

    typedef enum logic [1:0] {
        DBG_IDLE   = 2'd0,
        DBG_DELAY  = 2'd1,
        DBG_ASSERT = 2'd2
    } dbg_fsm_e;

    localparam int unsigned DEF_NUM_EVENTS     = 6;
    localparam int unsigned DEF_CNT_W          = 16;
    localparam int unsigned DEF_DLY_W          = 8;
    localparam int unsigned DEF_DBG_PULSE_LEN  = 4;
    localparam int unsigned DEF_DBG_HOLD       = 0;
    localparam int unsigned DEF_SLEEP_TIMEOUT  = 1000;
    localparam int unsigned DEF_FETCH_EN_DELAY = 2;

    localparam int unsigned EVT_ILLEGAL = 0;
    localparam int unsigned EVT_ECALL   = 1;
    localparam int unsigned EVT_WFI     = 2;
    localparam int unsigned EVT_EBREAK  = 3;
    localparam int unsigned EVT_DRET    = 4;
    localparam int unsigned EVT_MRET    = 5;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/core_ibex_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module core_ibex_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/core_ibex_dut_event_mon.sv
// Event/privilege/sleep monitor and debug_req/fetch_enable stimulus
// generator placed beside the Ibex core.
module core_ibex_dut_event_mon
    import core_ibex_dut_mon_pkg::*;
#(
    parameter int unsigned NUM_EVENTS     = DEF_NUM_EVENTS,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned DLY_W          = DEF_DLY_W,
    parameter int unsigned DBG_PULSE_LEN  = DEF_DBG_PULSE_LEN,
    parameter int unsigned DBG_HOLD       = DEF_DBG_HOLD,
    parameter int unsigned SLEEP_TIMEOUT  = DEF_SLEEP_TIMEOUT,
    parameter int unsigned FETCH_EN_DELAY = DEF_FETCH_EN_DELAY
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_EVENTS-1:0]       event_i,
    input  logic [1:0]                  priv_mode_i,
    input  logic                        core_sleep_i,
    input  logic                        clear_i,
    input  logic                        dbg_trig_i,
    input  logic [DLY_W-1:0]            dbg_delay_i,
    input  logic                        dbg_release_i,
    output logic [NUM_EVENTS*CNT_W-1:0] evt_cnt_o,
    output logic [NUM_EVENTS-1:0]       evt_seen_o,
    output logic [CNT_W-1:0]            priv_chg_cnt_o,
    output logic                        sleep_timeout_o,
    output logic                        debug_req_o,
    output logic                        dbg_busy_o,
    output logic                        fetch_enable_o
);

    localparam int unsigned RUN_W = cnt_width(SLEEP_TIMEOUT);
    localparam int unsigned PLS_W = cnt_width(DBG_PULSE_LEN);
    localparam int unsigned FE_W  = cnt_width(FETCH_EN_DELAY);

    localparam logic             SLEEP_EN  = (SLEEP_TIMEOUT != 0);
    localparam logic [RUN_W-1:0] SLEEP_MAX = RUN_W'(SLEEP_TIMEOUT);
    localparam logic [PLS_W-1:0] PLS_LAST  = PLS_W'(DBG_PULSE_LEN - 1);
    localparam logic [FE_W-1:0]  FE_LAST   = FE_W'(FETCH_EN_DELAY);

    // ---------------- event counters ----------------
    for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_evt
        core_ibex_sat_counter #(.WIDTH(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear_i),
            .inc   (event_i[k]),
            .count (evt_cnt_o[k*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_seen_o <= '0;
        end else if (clear_i) begin
            evt_seen_o <= '0;
        end else begin
            evt_seen_o <= evt_seen_o | event_i;
        end
    end

    // ---------------- privilege transitions ----------------
    logic [1:0] priv_q;
    logic       priv_valid_q;
    logic       priv_chg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            priv_q       <= '0;
            priv_valid_q <= 1'b0;
        end else begin
            priv_q       <= priv_mode_i;
            priv_valid_q <= 1'b1;
        end
    end

    assign priv_chg = priv_valid_q && (priv_mode_i != priv_q);

    core_ibex_sat_counter #(.WIDTH(CNT_W)) u_priv_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear_i),
        .inc   (priv_chg),
        .count (priv_chg_cnt_o)
    );

    // ---------------- sleep watchdog ----------------
    logic [RUN_W-1:0] run_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q           <= '0;
            sleep_timeout_o <= 1'b0;
        end else if (clear_i) begin
            run_q           <= '0;
            sleep_timeout_o <= 1'b0;
        end else begin
            if (!core_sleep_i) begin
                run_q <= '0;
            end else if (run_q < SLEEP_MAX) begin
                run_q <= run_q + 1'b1;
            end
            if (SLEEP_EN && (run_q == SLEEP_MAX)) begin
                sleep_timeout_o <= 1'b1;
            end
        end
    end

    // ---------------- debug request FSM ----------------
    dbg_fsm_e         state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [PLS_W-1:0] pls_q, pls_d;

    // DELAY exits on a count of 1 so the request rises d edges after the
    // sampling edge, i.e. d+1 edges after the trigger is presented.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        pls_d   = pls_q;
        unique case (state_q)
            DBG_IDLE: begin
                if (dbg_trig_i) begin
                    if (dbg_delay_i == '0) begin
                        state_d = DBG_ASSERT;
                        pls_d   = '0;
                    end else begin
                        state_d = DBG_DELAY;
                        dly_d   = dbg_delay_i;
                    end
                end
            end
            DBG_DELAY: begin
                if (dly_q == DLY_W'(1)) begin
                    state_d = DBG_ASSERT;
                    pls_d   = '0;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            DBG_ASSERT: begin
                if (DBG_HOLD != 0) begin
                    if (dbg_release_i) begin
                        state_d = DBG_IDLE;
                    end
                end else if (pls_q == PLS_LAST) begin
                    state_d = DBG_IDLE;
                end else begin
                    pls_d = pls_q + 1'b1;
                end
            end
            default: state_d = DBG_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DBG_IDLE;
            dly_q       <= '0;
            pls_q       <= '0;
            debug_req_o <= 1'b0;
            dbg_busy_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            pls_q       <= pls_d;
            debug_req_o <= (state_d == DBG_ASSERT);
            dbg_busy_o  <= (state_d != DBG_IDLE);
        end
    end

    // ---------------- fetch enable ----------------
    logic [FE_W-1:0] fe_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fe_cnt_q       <= '0;
            fetch_enable_o <= 1'b0;
        end else if (!fetch_enable_o) begin
            if (fe_cnt_q == FE_LAST) begin
                fetch_enable_o <= 1'b1;
            end else begin
                fe_cnt_q <= fe_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_ibex_dut_event_mon.sv
// Scoreboard bench: a pulse-mode and a hold-mode monitor share stimulus and
// are compared each cycle against a timeline-based reference model.
module tb_core_ibex_dut_event_mon;

    localparam int NE   = 6;
    localparam int CW   = 4;
    localparam int DW   = 8;
    localparam int PL   = 4;
    localparam int ST   = 10;
    localparam int FD   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int HMAX = 32'h7fffffff;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_D = 2'b10;
    localparam logic [1:0] PRV_M = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic [NE-1:0] event_i;
    logic [1:0]    priv_mode_i;
    logic          core_sleep_i, clear_i, dbg_trig_i, dbg_release_i;
    logic [DW-1:0] dbg_delay_i;

    logic [NE*CW-1:0] cnt_p, cnt_h;
    logic [NE-1:0]    seen_p, seen_h;
    logic [CW-1:0]    prv_p, prv_h;
    logic             slp_p, slp_h, req_p, req_h, busy_p, busy_h, fe_p, fe_h;

    always #5 clk = ~clk;

    core_ibex_dut_event_mon #(
        .NUM_EVENTS(NE), .CNT_W(CW), .DLY_W(DW), .DBG_PULSE_LEN(PL),
        .DBG_HOLD(0), .SLEEP_TIMEOUT(ST), .FETCH_EN_DELAY(FD)
    ) dut_p (
        .clk(clk), .reset(reset), .event_i(event_i), .priv_mode_i(priv_mode_i),
        .core_sleep_i(core_sleep_i), .clear_i(clear_i), .dbg_trig_i(dbg_trig_i),
        .dbg_delay_i(dbg_delay_i), .dbg_release_i(dbg_release_i),
        .evt_cnt_o(cnt_p), .evt_seen_o(seen_p), .priv_chg_cnt_o(prv_p),
        .sleep_timeout_o(slp_p), .debug_req_o(req_p), .dbg_busy_o(busy_p),
        .fetch_enable_o(fe_p)
    );

    core_ibex_dut_event_mon #(
        .NUM_EVENTS(NE), .CNT_W(CW), .DLY_W(DW), .DBG_PULSE_LEN(PL),
        .DBG_HOLD(1), .SLEEP_TIMEOUT(ST), .FETCH_EN_DELAY(FD)
    ) dut_h (
        .clk(clk), .reset(reset), .event_i(event_i), .priv_mode_i(priv_mode_i),
        .core_sleep_i(core_sleep_i), .clear_i(clear_i), .dbg_trig_i(dbg_trig_i),
        .dbg_delay_i(dbg_delay_i), .dbg_release_i(dbg_release_i),
        .evt_cnt_o(cnt_h), .evt_seen_o(seen_h), .priv_chg_cnt_o(prv_h),
        .sleep_timeout_o(slp_h), .debug_req_o(req_h), .dbg_busy_o(busy_h),
        .fetch_enable_o(fe_h)
    );

    typedef struct packed {
        logic [NE-1:0][CW-1:0] cnt;
        logic [NE-1:0]         seen;
        logic [CW-1:0]         prv;
        logic                  slp;
        logic                  fe;
        logic                  req_p;
        logic                  busy_p;
        logic                  req_h;
        logic                  busy_h;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: edge index k counts posedges since reset release.
    int            k;
    int            m_cnt[NE];
    logic [NE-1:0] m_seen;
    int            m_prv;
    logic [1:0]    m_prev;
    bit            m_pvalid;
    int            m_run;
    bit            m_slp;
    bit            p_act, h_act;
    int            p_start, p_end, h_start, h_end;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        k = 0;
        for (int i = 0; i < NE; i++) m_cnt[i] = 0;
        m_seen = '0; m_prv = 0; m_prev = '0; m_pvalid = 0;
        m_run = 0; m_slp = 0;
        p_act = 0; h_act = 0; p_start = 0; p_end = -1; h_start = 0; h_end = -1;
    endfunction

    // Drive one cycle of stimulus and queue what the outputs must show after the edge.
    task automatic step(input logic [NE-1:0] ev, input logic [1:0] pr, input logic slp,
                        input logic clr, input logic trig, input int dly, input logic rel);
        exp_t e;
        bit   idle;
        @(negedge clk);
        event_i = ev; priv_mode_i = pr; core_sleep_i = slp; clear_i = clr;
        dbg_trig_i = trig; dbg_delay_i = DW'(dly); dbg_release_i = rel;
        k++;
        for (int i = 0; i < NE; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (ev[i] && m_cnt[i] < CMAX) m_cnt[i]++;
        end
        m_seen = clr ? '0 : (m_seen | ev);
        if (clr) m_prv = 0;
        else if (m_pvalid && pr != m_prev && m_prv < CMAX) m_prv++;
        m_prev = pr; m_pvalid = 1;
        m_slp = clr ? 1'b0 : (m_slp | (m_run >= ST));
        m_run = clr ? 0 : (slp ? m_run + 1 : 0);
        // pulse mode: request window [k+d, k+d+PL-1] once accepted
        idle = !p_act || (k - 1 > p_end);
        if (idle && trig) begin
            p_act = 1; p_start = k + dly; p_end = k + dly + PL - 1;
        end
        // hold mode: window open-ended until a release seen while asserted
        idle = !h_act || (k - 1 > h_end);
        if (idle && trig) begin
            h_act = 1; h_start = k + dly; h_end = HMAX;
        end else if (h_act && h_end == HMAX && rel && k >= h_start + 1) begin
            h_end = k - 1;
        end
        for (int i = 0; i < NE; i++) e.cnt[i] = CW'(m_cnt[i]);
        e.seen   = m_seen;
        e.prv    = CW'(m_prv);
        e.slp    = m_slp;
        e.fe     = (k >= FD + 1);
        e.req_p  = p_act && k >= p_start && k <= p_end;
        e.busy_p = p_act && k <= p_end;
        e.req_h  = h_act && k >= h_start && k <= h_end;
        e.busy_h = h_act && k <= h_end;
        exp_q.push_back(e);
    endtask

    task automatic idle_step(input int n);
        for (int i = 0; i < n; i++) step('0, priv_mode_i, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Asserts reset between edges and checks the asynchronous effect.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        event_i = '0; core_sleep_i = 1'b0; clear_i = 1'b0;
        dbg_trig_i = 1'b0; dbg_delay_i = '0; dbg_release_i = 1'b0;
        #1;
        chk("rst_req_p", req_p, 0);   chk("rst_req_h", req_h, 0);
        chk("rst_busy_p", busy_p, 0); chk("rst_busy_h", busy_h, 0);
        chk("rst_fe_p", fe_p, 0);     chk("rst_fe_h", fe_h, 0);
        chk("rst_cnt_p", cnt_p, 0);   chk("rst_cnt_h", cnt_h, 0);
        chk("rst_seen_p", seen_p, 0); chk("rst_prv_p", prv_p, 0);
        chk("rst_slp_p", slp_p, 0);   chk("rst_slp_h", slp_h, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    exp_t me;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            for (int i = 0; i < NE; i++) begin
                chk($sformatf("cnt_p[%0d]", i), cnt_p[i*CW +: CW], me.cnt[i]);
                chk($sformatf("cnt_h[%0d]", i), cnt_h[i*CW +: CW], me.cnt[i]);
            end
            chk("seen_p", seen_p, me.seen); chk("seen_h", seen_h, me.seen);
            chk("prv_p", prv_p, me.prv);    chk("prv_h", prv_h, me.prv);
            chk("slp_p", slp_p, me.slp);    chk("slp_h", slp_h, me.slp);
            chk("fe_p", fe_p, me.fe);       chk("fe_h", fe_h, me.fe);
            chk("req_p", req_p, me.req_p);  chk("busy_p", busy_p, me.busy_p);
            chk("req_h", req_h, me.req_h);  chk("busy_h", busy_h, me.busy_h);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [1:0] pr;
        logic       sl;
        reset = 1'b1;
        event_i = '0; priv_mode_i = PRV_M; core_sleep_i = 1'b0; clear_i = 1'b0;
        dbg_trig_i = 1'b0; dbg_delay_i = '0; dbg_release_i = 1'b0;
        model_reset();
        apply_reset();

        // privilege walk M,U,U,M,D right after reset release (also covers fetch delay)
        step('0, PRV_M, 0, 0, 0, 0, 0);
        step('0, PRV_U, 0, 0, 0, 0, 0);
        step('0, PRV_U, 0, 0, 0, 0, 0);
        step('0, PRV_M, 0, 0, 0, 0, 0);
        step('0, PRV_D, 0, 0, 0, 0, 0);
        idle_step(2);

        // five strobes on channel 1, then clear colliding with a strobe
        for (int i = 0; i < 5; i++) step(6'b000010, PRV_D, 0, 0, 0, 0, 0);
        step(6'b000010, PRV_D, 0, 1, 0, 0, 0);
        idle_step(2);

        // saturation on channel 0
        for (int i = 0; i < 20; i++) step(6'b000001, PRV_D, 0, 0, 0, 0, 0);
        idle_step(2);

        // delayed pulse with a second trigger arriving during DELAY
        step('0, PRV_D, 0, 0, 1, 3, 0);
        step('0, PRV_D, 0, 0, 0, 0, 0);
        step('0, PRV_D, 0, 0, 1, 0, 0);
        idle_step(8);
        step('0, PRV_D, 0, 0, 0, 0, 1);
        idle_step(2);

        // hold-mode request interrupted by reset two cycles later
        step('0, PRV_D, 0, 0, 1, 0, 0);
        step('0, PRV_D, 0, 0, 0, 0, 0);
        apply_reset();

        // sleep watchdog: 9 high, 1 low, 10 high, then hold flag until clear
        step('0, PRV_M, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step('0, PRV_M, 1, 0, 0, 0, 0);
        step('0, PRV_M, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step('0, PRV_M, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step('0, PRV_M, 0, 0, 0, 0, 0);
        step('0, PRV_M, 0, 1, 0, 0, 0);
        idle_step(2);

        // randomized traffic with occasional resets
        pr = PRV_M;
        sl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) pr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) sl = ~sl;
            step(NE'($urandom & $urandom), pr, sl,
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 5)),
                 $urandom_range(0, 4) == 0);
            if (n % 700 == 699) apply_reset();
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_ibex_dut_event_mon.md
Name: core_ibex_dut_event_mon

Overview:
- Parametrised, synthesizable successor to the DUT probe interface, instantiated beside the Ibex core in the UVM testbench.
- Per channel, it counts core events such as illegal_instr, ecall, wfi, ebreak, dret and mret.
- Tracks privilege-mode transitions and watches for excessive core_sleep.
- Drives debug_req and fetch_enable from a programmable stimulus FSM instead of raw clocking-block writes.
- All outputs are registered.

Parameters:
- NUM_EVENTS, 6: number of event input channels.
- CNT_W, 16: width of each event counter and of the priv-change counter.
- DLY_W, 8: width of the debug-request delay field.
- DBG_PULSE_LEN, 4: cycles debug_req_o is held high in pulse mode (must be ≥1).
- DBG_HOLD, 0: 0 = pulse mode; 1 = hold debug_req_o until dbg_release_i.
- SLEEP_TIMEOUT, 1000: consecutive core_sleep cycles that raise sleep_timeout_o; 0 disables the watchdog.
- FETCH_EN_DELAY, 2: cycles after reset release before fetch_enable_o rises.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- event_i  in  NUM_EVENTS  per-channel single-cycle event strobes.
- priv_mode_i  in  2  ibex_pkg::priv_lvl_e, current privilege level.
- core_sleep_i  in  1  core sleep indication.
- clear_i  in  1  synchronous clear of counters, sticky flags and watchdog.
- dbg_trig_i  in  1  request a debug_req sequence.
- dbg_delay_i  in  DLY_W  cycles to wait after the trigger before asserting.
- dbg_release_i  in  1  ends the hold in DBG_HOLD=1 mode.
- evt_cnt_o  out  NUM_EVENTS*CNT_W  packed counters; channel k occupies [k*CNT_W +: CNT_W].
- evt_seen_o  out  NUM_EVENTS  sticky per-channel "event occurred" flags.
- priv_chg_cnt_o  out  CNT_W  number of privilege-level transitions.
- sleep_timeout_o  out  1  sticky watchdog flag.
- debug_req_o  out  1  debug request to the core.
- dbg_busy_o  out  1  high whenever the FSM is not in IDLE.
- fetch_enable_o  out  1  fetch enable to the core.

Behaviour:
- Reset values:
  - All outputs are 0; the FSM is in IDLE.
  - The privilege-mode history register is marked invalid.
  - The fetch-enable delay counter is 0.
- Event counters (per channel):
  - On each clk where event_i[k]=1 the counter increments, saturating at 2^CNT_W-1 (no wrap).
  - evt_seen_o[k] is set on the same edge.
  - Outputs update one cycle after the strobe.
- clear_i:
  - Zeroes all counters, evt_seen_o, priv_chg_cnt_o, sleep_timeout_o and the sleep run counter.
  - clear_i wins over a same-cycle event: the result is 0, not 1.
  - Does not affect the debug FSM or fetch_enable_o.
- Priv-change counter:
  - The previous priv_mode_i is registered each cycle.
  - The counter increments, saturating, when the history is valid and priv_mode_i differs from the stored value.
  - No increment in the first cycle after reset release; that cycle only marks the history valid.
- Sleep watchdog:
  - The run counter increments while core_sleep_i=1 and resets to 0 when core_sleep_i=0.
  - When the run counter reaches SLEEP_TIMEOUT, sleep_timeout_o rises on the next edge and stays high until clear_i or reset.
  - The run counter saturates; it does not wrap.
- Debug FSM, states IDLE, DELAY, ASSERT:
  - IDLE with dbg_trig_i=1 and dbg_delay_i=0: go to ASSERT; debug_req_o is high on the next edge.
  - IDLE with dbg_trig_i=1 and dbg_delay_i=d>0: latch d and go to DELAY. debug_req_o rises exactly d+1 edges after the trigger edge.
  - ASSERT in pulse mode (DBG_HOLD=0): debug_req_o is high for exactly DBG_PULSE_LEN cycles, then the FSM returns to IDLE.
  - ASSERT in hold mode (DBG_HOLD=1): debug_req_o stays high until dbg_release_i=1 is sampled, then the FSM returns to IDLE; debug_req_o is 0 the next cycle.
  - dbg_release_i is ignored outside ASSERT.
  - dbg_trig_i outside IDLE is dropped (no queueing).
  - A trigger sampled in the same cycle the FSM returns to IDLE is also dropped; the FSM accepts triggers only when already in IDLE.
- fetch_enable_o:
  - After reset deasserts, a counter runs for FETCH_EN_DELAY cycles; fetch_enable_o then rises and stays high until the next reset.
  - FETCH_EN_DELAY=0 means fetch_enable_o rises on the first edge after reset release.
- Reset mid-operation: asynchronously forces all reset values; any in-flight debug sequence is abandoned with debug_req_o=0 immediately.

Decomposition:
- ibex_pkg (existing): priv_lvl_e.
- New core_ibex_dut_mon_pkg:
  - dbg_fsm_e (IDLE/DELAY/ASSERT).
  - Default parameter constants.
  - Channel index constants, e.g. EVT_ILLEGAL=0, EVT_ECALL=1 … EVT_MRET=5.
- Sub-module core_ibex_sat_counter (parametrised width; inc/clear inputs; clear priority), instantiated NUM_EVENTS+1 times.
- The debug FSM stays inline.

Test Plan:
- Reset release with FETCH_EN_DELAY=2:
  - fetch_enable_o rises on the 3rd posedge after reset falls.
  - All counters read 0.
- Strobe event_i[1] 5 times, then clear_i and event_i[1] in the same cycle:
  - Channel 1 reads 5 and evt_seen_o=6'b000010.
  - After the clear cycle, channel 1 reads 0.
- CNT_W=4, hold event_i[0] for 20 cycles: channel 0 reads 15 and stays there (saturation).
- priv_mode_i M→U→U→M→D after reset: priv_chg_cnt_o=3.
- dbg_trig_i with dbg_delay_i=3, DBG_PULSE_LEN=4, plus a second trigger during DELAY:
  - debug_req_o high on edges 4–7 after the trigger, then low.
  - The second trigger is ignored.
- DBG_HOLD=1 trigger with delay 0, reset asserted 2 cycles later:
  - debug_req_o is high 1 edge after the trigger.
  - It drops asynchronously at reset; dbg_busy_o=0.
- SLEEP_TIMEOUT=10:
  - core_sleep_i high for 9 cycles, low 1, then high for 10: sleep_timeout_o=0 after the first run and 1 after the second.
  - The flag stays 1 until clear_i.
